// File: rtl/alu_arbiter_if.sv
// Bundle of core request, aux requests, ALU drive/return and registered result
// signals shared between the ALU arbiter and its surroundings.
interface alu_arbiter_if #(
  parameter int WORD_WIDTH = 32
);
  // core request
  logic                       core_valid;
  logic [WORD_WIDTH-1:0]      core_a;
  logic [WORD_WIDTH-1:0]      core_b;
  logic                       core_ic;
  logic [3:0]                 core_opcode;
  logic                       core_store_carry;
  logic                       core_store_overflow;
  logic                       core_ready;
  // aux requests
  logic [1:0]                 aux_valid;
  logic [1:0][WORD_WIDTH-1:0] aux_a;
  logic [1:0][WORD_WIDTH-1:0] aux_b;
  logic [1:0]                 aux_ic;
  logic [1:0][3:0]            aux_opcode;
  logic [1:0]                 aux_ready;
  // shared ALU
  logic [WORD_WIDTH-1:0]      alu_a;
  logic [WORD_WIDTH-1:0]      alu_b;
  logic                       alu_ic;
  logic [3:0]                 alu_opcode;
  logic [WORD_WIDTH-1:0]      alu_out;
  logic                       alu_oc;
  logic                       alu_oo;
  // registered results and flags
  logic [WORD_WIDTH-1:0]      core_result;
  logic                       core_result_valid;
  logic [WORD_WIDTH-1:0]      aux_result;
  logic [1:0]                 aux_result_valid;
  logic                       carry;
  logic                       overflow;

  modport slave (
    input  core_valid, core_a, core_b, core_ic, core_opcode,
           core_store_carry, core_store_overflow,
    output core_ready,
    input  aux_valid, aux_a, aux_b, aux_ic, aux_opcode,
    output aux_ready,
    output alu_a, alu_b, alu_ic, alu_opcode,
    input  alu_out, alu_oc, alu_oo,
    output core_result, core_result_valid, aux_result, aux_result_valid,
           carry, overflow
  );

  modport master (
    output core_valid, core_a, core_b, core_ic, core_opcode,
           core_store_carry, core_store_overflow,
    input  core_ready,
    output aux_valid, aux_a, aux_b, aux_ic, aux_opcode,
    input  aux_ready,
    input  alu_a, alu_b, alu_ic, alu_opcode,
    output alu_out, alu_oc, alu_oo,
    input  core_result, core_result_valid, aux_result, aux_result_valid,
           carry, overflow
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one ALU between the core pipeline and two aux requesters: core priority,
// round-robin between aux ports, starvation counter forcing an aux grant.
module alu_arbiter #(
  parameter int WORD_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] CNT_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  rr_q, rr_d;
  logic [WORD_WIDTH-1:0] core_result_q, core_result_d;
  logic                  core_result_valid_q, core_result_valid_d;
  logic [WORD_WIDTH-1:0] aux_result_q, aux_result_d;
  logic [1:0]            aux_result_valid_q, aux_result_valid_d;
  logic                  carry_q, carry_d;
  logic                  overflow_q, overflow_d;

  logic       aux_any;
  logic       stall;
  logic       core_gnt;
  logic [1:0] aux_gnt;
  logic       aux_sel;

  // Grant: core first unless an aux request has waited out the starvation limit.
  always_comb begin
    aux_any  = |bus.aux_valid;
    stall    = (starve_cnt_q == CNT_LIMIT) && aux_any;
    core_gnt = bus.core_valid && !stall;
    aux_gnt  = 2'b00;
    if (!core_gnt && aux_any) begin
      if (&bus.aux_valid) aux_gnt[rr_q] = 1'b1;
      else                aux_gnt     = bus.aux_valid;
    end
    aux_sel = aux_gnt[1];
  end

  always_comb begin
    if (|aux_gnt || !aux_any)          starve_cnt_d = 4'd0;
    else if (starve_cnt_q == CNT_LIMIT) starve_cnt_d = CNT_LIMIT;
    else                                starve_cnt_d = starve_cnt_q + 4'd1;

    rr_d = rr_q;
    if (aux_gnt[0]) rr_d = 1'b1;
    if (aux_gnt[1]) rr_d = 1'b0;
  end

  // Operand mux; an unowned ALU sees a NOP with zero operands.
  always_comb begin
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_ic     = 1'b0;
    bus.alu_opcode = OP_NOP;
    if (core_gnt) begin
      bus.alu_a      = bus.core_a;
      bus.alu_b      = bus.core_b;
      bus.alu_ic     = bus.core_ic;
      bus.alu_opcode = bus.core_opcode;
    end else if (|aux_gnt) begin
      bus.alu_a      = bus.aux_a[aux_sel];
      bus.alu_b      = bus.aux_b[aux_sel];
      bus.alu_ic     = bus.aux_ic[aux_sel];
      bus.alu_opcode = bus.aux_opcode[aux_sel];
    end
  end

  always_comb begin
    core_result_d       = core_gnt ? bus.alu_out : core_result_q;
    core_result_valid_d = core_gnt;
    aux_result_d        = (|aux_gnt) ? bus.alu_out : aux_result_q;
    aux_result_valid_d  = aux_gnt;
    // only core ops are architecturally visible in the flags
    carry_d    = (core_gnt && bus.core_store_carry)    ? bus.alu_oc : carry_q;
    overflow_d = (core_gnt && bus.core_store_overflow) ? bus.alu_oo : overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_q        <= 4'd0;
      rr_q                <= 1'b0;
      core_result_q       <= '0;
      core_result_valid_q <= 1'b0;
      aux_result_q        <= '0;
      aux_result_valid_q  <= 2'b00;
      carry_q             <= 1'b0;
      overflow_q          <= 1'b0;
    end else begin
      starve_cnt_q        <= starve_cnt_d;
      rr_q                <= rr_d;
      core_result_q       <= core_result_d;
      core_result_valid_q <= core_result_valid_d;
      aux_result_q        <= aux_result_d;
      aux_result_valid_q  <= aux_result_valid_d;
      carry_q             <= carry_d;
      overflow_q          <= overflow_d;
    end
  end

  assign bus.core_ready        = !stall;
  assign bus.aux_ready         = aux_gnt;
  assign bus.core_result       = core_result_q;
  assign bus.core_result_valid = core_result_valid_q;
  assign bus.aux_result        = aux_result_q;
  assign bus.aux_result_valid  = aux_result_valid_q;
  assign bus.carry             = carry_q;
  assign bus.overflow          = overflow_q;
endmodule
